ccd_dark_level_sub: RTL and testbench

//  Optical-black (dark-level) correction between the AD9945 output register and ccd2axis, in the pixel_clk domain.

---
 rtl/ccd_dark_level_sub_pkg.sv | 16 +
 rtl/ccd_sat_addsub.sv | 34 +++
 rtl/ccd_dark_level_sub.sv | 176 +++++++++++++++++
 tb/tb_ccd_dark_level_sub.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ccd_dark_level_sub_pkg.sv
// Shared definitions for the CCD dark-level correction slice: FSM encoding and
// sensor column geometry common with ccd2axis.
package ccd_dark_level_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_ACC  = 2'd2,
        ST_CORR = 2'd3
    } dls_state_e;

    localparam int PRE_DUMMY_COLS  = 32;
    localparam int EFFECT_COLS     = 2048;
    localparam int POST_DUMMY_COLS = 8;

endpackage

// File: rtl/ccd_sat_addsub.sv
// Combinational pix - sub + add in signed DATA_WIDTH+2 bits, clamped to the
// unsigned DATA_WIDTH range. Reusable by later gain/offset stages.
module ccd_sat_addsub #(
    parameter int DATA_WIDTH = 12
) (
    input  logic [DATA_WIDTH-1:0] pix_i,
    input  logic [DATA_WIDTH-1:0] sub_i,
    input  logic [DATA_WIDTH-1:0] add_i,
    output logic [DATA_WIDTH-1:0] res_o
);

    localparam int SW = DATA_WIDTH + 2;

    logic signed [SW-1:0] sum_s;

    // Non-negative results exceed the range exactly when bit DATA_WIDTH is set.
    function automatic logic [DATA_WIDTH-1:0] clamp(input logic signed [SW-1:0] v);
        logic [DATA_WIDTH-1:0] r;
        if (v[SW-1]) begin
            r = '0;
        end else if (v[DATA_WIDTH]) begin
            r = '1;
        end else begin
            r = v[DATA_WIDTH-1:0];
        end
        return r;
    endfunction

    always_comb begin
        sum_s = $signed({2'b00, pix_i}) - $signed({2'b00, sub_i}) + $signed({2'b00, add_i});
        res_o = clamp(sum_s);
    end

endmodule

// File: rtl/ccd_dark_level_sub.sv
// Optical-black correction: averages a window of shielded pixels at the start of
// each line, IIR-filters it across lines, and subtracts it (plus pedestal) from the rest.
module ccd_dark_level_sub
    import ccd_dark_level_sub_pkg::*;
#(
    parameter int DATA_WIDTH  = 12,
    parameter int DARK_START  = 4,
    parameter int DARK_LOG2   = 4,
    parameter int ALPHA_SHIFT = 2
) (
    input  logic                  pixel_clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] pedestal,
    input  logic                  s_tvalid,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    output logic                  m_tvalid,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [DATA_WIDTH-1:0] dark_level,
    output logic                  dark_valid,
    output logic                  line_short
);

    localparam int WIN_END = DARK_START + 2**DARK_LOG2;
    localparam int CNT_W   = $clog2(WIN_END + 1);
    localparam int ACC_W   = DATA_WIDTH + DARK_LOG2;
    localparam logic [CNT_W-1:0] WIN_FIRST = CNT_W'(DARK_START);
    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WIN_END - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(WIN_END);

    dls_state_e             state_q, state_d;
    logic [CNT_W-1:0]       pix_cnt_q, pix_cnt_d, nxt_cnt_s;
    logic [ACC_W-1:0]       acc_q, acc_d, acc_sum_s;
    logic [DATA_WIDTH-1:0]  dark_q, dark_d, avg_s, iir_s, ped_q, ped_d, sat_s;
    logic signed [DATA_WIDTH:0] diff_s, step_s;
    logic                   dark_valid_q, dark_valid_d;
    logic                   in_win_s, win_last_s, corr_flag_s, short_s;
    logic                   line_short_q, line_short_d;
    logic [DATA_WIDTH-1:0]  pix1_q, pix1_d, sat1_q, sat1_d, m_tdata_q, m_tdata_d;
    logic                   corr1_q, corr1_d, vld1_q, vld1_d, m_tvalid_q, m_tvalid_d;

    // Pixel index decides which phase of the line the next pixel belongs to.
    function automatic dls_state_e state_at(input logic [CNT_W-1:0] idx);
        dls_state_e s;
        if (idx < WIN_FIRST) begin
            s = ST_PRE;
        end else if (idx <= WIN_LAST) begin
            s = ST_ACC;
        end else begin
            s = ST_CORR;
        end
        return s;
    endfunction

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_PRE, ST_ACC: begin
                if (s_tvalid) state_d = state_at(nxt_cnt_s);
                else          state_d = ST_IDLE;
            end
            ST_CORR: begin
                if (s_tvalid) state_d = ST_CORR;
                else          state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        corr_flag_s = 1'b0;
        short_s     = 1'b0;
        case (state_q)
            ST_CORR:        corr_flag_s = en && s_tvalid;
            ST_PRE, ST_ACC: short_s     = !s_tvalid;
            default: begin
                corr_flag_s = 1'b0;
                short_s     = 1'b0;
            end
        endcase
    end

    // Window accumulation, average, and the dark IIR update on the last window pixel.
    always_comb begin
        nxt_cnt_s  = (pix_cnt_q == CNT_MAX) ? pix_cnt_q : pix_cnt_q + CNT_W'(1);
        pix_cnt_d  = s_tvalid ? nxt_cnt_s : '0;
        in_win_s   = s_tvalid && (pix_cnt_q >= WIN_FIRST) && (pix_cnt_q <= WIN_LAST);
        win_last_s = s_tvalid && (pix_cnt_q == WIN_LAST);
        acc_sum_s  = ((pix_cnt_q == WIN_FIRST) ? '0 : acc_q) + ACC_W'(s_tdata);
        avg_s      = DATA_WIDTH'(acc_sum_s >> DARK_LOG2);
        diff_s     = $signed({1'b0, avg_s}) - $signed({1'b0, dark_q});
        step_s     = diff_s >>> ALPHA_SHIFT;
        iir_s      = DATA_WIDTH'($signed({1'b0, dark_q}) + step_s);

        if (!s_tvalid)     acc_d = '0;
        else if (in_win_s) acc_d = acc_sum_s;
        else               acc_d = acc_q;

        dark_d       = dark_q;
        dark_valid_d = dark_valid_q;
        if (win_last_s) begin
            dark_valid_d = 1'b1;
            if (!dark_valid_q || (ALPHA_SHIFT == 0)) dark_d = avg_s;
            else                                     dark_d = iir_s;
        end else begin
            dark_d       = dark_q;
            dark_valid_d = dark_valid_q;
        end

        if ((state_q == ST_IDLE) && s_tvalid) ped_d = pedestal;
        else                                  ped_d = ped_q;
        line_short_d = short_s;
    end

    ccd_sat_addsub #(.DATA_WIDTH(DATA_WIDTH)) u_sat (
        .pix_i (s_tdata),
        .sub_i (dark_q),
        .add_i (ped_q),
        .res_o (sat_s)
    );

    always_comb begin
        vld1_d     = s_tvalid;
        corr1_d    = corr_flag_s;
        pix1_d     = s_tvalid ? s_tdata : pix1_q;
        sat1_d     = s_tvalid ? sat_s : sat1_q;
        m_tvalid_d = vld1_q;
        if (vld1_q) m_tdata_d = corr1_q ? sat1_q : pix1_q;
        else        m_tdata_d = m_tdata_q;
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            pix_cnt_q    <= '0;
            acc_q        <= '0;
            dark_q       <= '0;
            dark_valid_q <= 1'b0;
            ped_q        <= '0;
            line_short_q <= 1'b0;
            pix1_q       <= '0;
            sat1_q       <= '0;
            corr1_q      <= 1'b0;
            vld1_q       <= 1'b0;
            m_tdata_q    <= '0;
            m_tvalid_q   <= 1'b0;
        end else begin
            pix_cnt_q    <= pix_cnt_d;
            acc_q        <= acc_d;
            dark_q       <= dark_d;
            dark_valid_q <= dark_valid_d;
            ped_q        <= ped_d;
            line_short_q <= line_short_d;
            pix1_q       <= pix1_d;
            sat1_q       <= sat1_d;
            corr1_q      <= corr1_d;
            vld1_q       <= vld1_d;
            m_tdata_q    <= m_tdata_d;
            m_tvalid_q   <= m_tvalid_d;
        end
    end

    assign m_tvalid   = m_tvalid_q;
    assign m_tdata    = m_tdata_q;
    assign dark_level = dark_q;
    assign dark_valid = dark_valid_q;
    assign line_short = line_short_q;

endmodule

// File: tb/tb_ccd_dark_level_sub.sv
// Randomized scoreboard bench for ccd_dark_level_sub: per-line reference model
// pushes expected pixels; a negedge monitor pops and compares them.
module tb_ccd_dark_level_sub;

    localparam int DW = 12;
    localparam int DS = 4;
    localparam int LG = 4;
    localparam int AS = 2;
    localparam int N  = 16;

    logic          pixel_clk = 1'b0;
    logic          rst       = 1'b1;
    logic          en        = 1'b1;
    logic [DW-1:0] pedestal  = '0;
    logic          s_tvalid  = 1'b0;
    logic [DW-1:0] s_tdata   = '0;
    logic          m_tvalid;
    logic [DW-1:0] m_tdata;
    logic [DW-1:0] dark_level;
    logic          dark_valid;
    logic          line_short;

    always #5 pixel_clk = ~pixel_clk;

    ccd_dark_level_sub #(
        .DATA_WIDTH(DW), .DARK_START(DS), .DARK_LOG2(LG), .ALPHA_SHIFT(AS)
    ) dut (
        .pixel_clk  (pixel_clk),
        .rst        (rst),
        .en         (en),
        .pedestal   (pedestal),
        .s_tvalid   (s_tvalid),
        .s_tdata    (s_tdata),
        .m_tvalid   (m_tvalid),
        .m_tdata    (m_tdata),
        .dark_level (dark_level),
        .dark_valid (dark_valid),
        .line_short (line_short)
    );

    typedef struct {
        int data;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   short_seen = 0;
    int   short_exp = 0;
    int   m_dark = 0;
    int   m_dv = 0;

    always @(posedge pixel_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per output beat, also checks 2-cycle latency.
    initial begin
        exp_t e;
        forever begin
            @(negedge pixel_clk);
            if (!rst) begin
                if (line_short) short_seen++;
                if (m_tvalid) begin
                    if (exp_q.size() == 0) begin
                        check("out_without_input", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("m_tdata", int'(m_tdata), e.data);
                        check("latency", cyc - e.cyc, 2);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst      = 1'b1;
        s_tvalid = 1'b0;
        exp_q.delete();
        m_dark = 0;
        m_dv   = 0;
        repeat (3) @(posedge pixel_clk);
        #1;
        check("rst_m_tvalid", int'(m_tvalid), 0);
        check("rst_m_tdata", int'(m_tdata), 0);
        check("rst_dark_level", int'(dark_level), 0);
        check("rst_dark_valid", int'(dark_valid), 0);
        check("rst_line_short", int'(line_short), 0);
        rst = 1'b0;
        @(posedge pixel_clk);
        #1;
    endtask

    // win_v/rest_v < 0 mean random values; en_mode 0=off,1=on,2=random per pixel;
    // rst_at >= 0 aborts the line with a reset at that pixel.
    task automatic run_line(input int len, input int win_v, input int rest_v, input int ped,
                            input int en_mode, input int gap, input int rst_at);
        int px[];
        int sum;
        int avg;
        int v;
        int e_i;
        bit complete;
        bit aborted;
        px  = new[len];
        sum = 0;
        aborted = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (i >= DS && i < DS + N) begin
                px[i] = (win_v >= 0) ? win_v : int'($urandom_range(0, 4095));
                sum  += px[i];
            end else begin
                px[i] = (rest_v >= 0) ? rest_v : int'($urandom_range(0, 4095));
            end
        end
        complete = (len >= DS + N);
        if (complete) begin
            avg = sum / N;
            if (m_dv == 0 || AS == 0) m_dark = avg;
            else                      m_dark = m_dark + ((avg - m_dark) >>> AS);
            m_dv = 1;
        end else begin
            short_exp++;
        end
        for (int i = 0; i < len; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                exp_q.delete();
                m_dark = 0;
                m_dv   = 0;
                for (int k = 0; k < 3; k++) begin
                    s_tdata = DW'($urandom_range(0, 4095));
                    @(posedge pixel_clk);
                    #1;
                    check("midline_rst_m_tvalid", int'(m_tvalid), 0);
                end
                s_tvalid = 1'b0;
                rst      = 1'b0;
                aborted  = 1'b1;
                break;
            end
            e_i = (en_mode == 2) ? int'($urandom_range(0, 1)) : en_mode;
            s_tvalid = 1'b1;
            s_tdata  = DW'(px[i]);
            en       = e_i[0];
            if (i == 0)            pedestal = DW'(ped);
            else if (en_mode == 2) pedestal = DW'($urandom_range(0, 4095));
            v = px[i];
            if (complete && i >= DS + N && e_i == 1) begin
                v = px[i] - m_dark + ped;
                if (v < 0)    v = 0;
                if (v > 4095) v = 4095;
            end
            exp_q.push_back('{v, cyc});
            @(posedge pixel_clk);
            #1;
        end
        check("dark_level", int'(dark_level), m_dark);
        check("dark_valid", int'(dark_valid), m_dv);
        s_tvalid = 1'b0;
        s_tdata  = DW'($urandom_range(0, 4095));
        if (!aborted) en = 1'($urandom_range(0, 1));
        repeat (gap) begin
            @(posedge pixel_clk);
            #1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Basic correction, first line loads dark directly.
        run_line(2088, 200, 1000, 64, 1, 3, -1);
        check("t1_dark", int'(dark_level), 200);
        check("t1_dark_valid", int'(dark_valid), 1);

        // Clamp low and high.
        do_reset();
        run_line(40, 300, 100, 0, 1, 3, -1);
        do_reset();
        run_line(40, 0, 4000, 200, 1, 3, -1);

        // IIR across three lines.
        do_reset();
        run_line(60, 400, -1, 10, 1, 2, -1);
        check("t3_dark_l1", int'(dark_level), 400);
        run_line(60, 800, -1, 10, 1, 2, -1);
        check("t3_dark_l2", int'(dark_level), 500);
        run_line(60, 0, -1, 10, 1, 3, -1);
        check("t3_dark_l3", int'(dark_level), 375);

        // Short line: pulse once, dark unchanged, pixels pass through.
        run_line(10, -1, -1, 50, 1, 3, -1);
        check("t4_short_count", short_seen, short_exp);
        check("t4_dark", int'(dark_level), 375);

        // Bypass still tracks dark.
        do_reset();
        run_line(80, 300, -1, 77, 0, 3, -1);
        check("t5_dark", int'(dark_level), 300);

        // Reset in the middle of a line.
        do_reset();
        run_line(1200, 500, -1, 30, 1, 3, 1000);
        run_line(100, 150, -1, 30, 1, 3, -1);
        check("t6_dark", int'(dark_level), 150);
        check("t6_short_count", short_seen, short_exp);

        // Random lines, gaps down to a single cycle.
        for (int l = 0; l < 40; l++) begin
            int len;
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 19))
                                              : int'($urandom_range(20, 150));
            run_line(len, -1, -1, int'($urandom_range(0, 4095)), 2,
                     int'($urandom_range(1, 3)), -1);
        end

        repeat (6) @(posedge pixel_clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("line_short_count", short_seen, short_exp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
